// File: rtl/lsu_split_ctrl.sv
// rtl/lsu_split_ctrl.sv - load/store unit issuing misaligned accesses as two word-aligned bus beats
package lsu_split_ctrl_pkg;
  typedef enum logic [1:0] {
    MEM_BYTE = 2'd0,
    MEM_HALF = 2'd1,
    MEM_WORD = 2'd2
  } mem_size_e;
endpackage

module lsu_split_ctrl
  import lsu_split_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W           = 32,
  parameter bit          SPLIT_MISALIGNED = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_we_i,
  input  logic [31:0]       req_wdata_i,
  input  mem_size_e         req_size_i,
  input  logic              req_signed_i,
  output logic              resp_valid_o,
  output logic [31:0]       resp_rdata_o,
  output logic              resp_err_o,
  output logic              resp_misaligned_o,
  output logic              bus_req_o,
  input  logic              bus_gnt_i,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic              bus_we_o,
  output logic [3:0]        bus_be_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_rvalid_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i
);

  typedef enum logic [2:0] {IDLE, REQ0, RSP0, REQ1, RSP1, REJ} state_e;

  localparam logic [ADDR_W-3:0] WORD_INC = {{(ADDR_W-3){1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  mem_size_e         size_q;
  logic              signed_q;
  logic [7:0]        be8_q, be8_d;
  logic [63:0]       wd64_q, wd64_d;
  logic              mis_q, mis_d;
  logic              split_q, split_d;
  logic [31:0]       lo_q;
  logic              ready_q;
  logic              resp_valid_q, resp_err_q, resp_mis_q;
  logic [31:0]       resp_rdata_q;
  logic              bus_req_q, bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [3:0]        bus_be_q;
  logic [31:0]       bus_wdata_q;

  // Byte lanes and write data are laid out over two consecutive words, so the
  // upper half of be8/wd64 belongs to the second beat.
  always_comb begin
    logic [7:0]  mask8;
    logic [31:0] wmask;
    mask8 = 8'h0F;
    wmask = req_wdata_i;
    mis_d = 1'b0;
    unique case (req_size_i)
      MEM_BYTE: begin
        mask8 = 8'h01;
        wmask = {24'b0, req_wdata_i[7:0]};
      end
      MEM_HALF: begin
        mask8 = 8'h03;
        wmask = {16'b0, req_wdata_i[15:0]};
        mis_d = req_addr_i[0];
      end
      default: mis_d = |req_addr_i[1:0];
    endcase
    be8_d   = mask8 << req_addr_i[1:0];
    wd64_d  = {32'b0, wmask} << {req_addr_i[1:0], 3'b000};
    split_d = |be8_d[7:4];
  end

  function automatic logic [31:0] load_align(input logic [63:0] r64, input logic [1:0] o,
                                             input mem_size_e sz, input logic sgn);
    logic [31:0] x;
    x = 32'(r64 >> {o, 3'b000});
    unique case (sz)
      MEM_BYTE: load_align = {{24{sgn & x[7]}}, x[7:0]};
      MEM_HALF: load_align = {{16{sgn & x[15]}}, x[15:0]};
      default:  load_align = x;
    endcase
  endfunction

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      we_q         <= 1'b0;
      size_q       <= MEM_BYTE;
      signed_q     <= 1'b0;
      be8_q        <= '0;
      wd64_q       <= '0;
      mis_q        <= 1'b0;
      split_q      <= 1'b0;
      lo_q         <= '0;
      ready_q      <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      resp_mis_q   <= 1'b0;
      bus_req_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_we_q     <= 1'b0;
      bus_be_q     <= '0;
      bus_wdata_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            addr_q   <= req_addr_i;
            we_q     <= req_we_i;
            size_q   <= req_size_i;
            signed_q <= req_signed_i;
            be8_q    <= be8_d;
            wd64_q   <= wd64_d;
            mis_q    <= mis_d;
            split_q  <= split_d;
            ready_q  <= 1'b0;
            if (mis_d && !SPLIT_MISALIGNED) begin
              state_q <= REJ;
            end else begin
              state_q     <= REQ0;
              bus_req_q   <= 1'b1;
              bus_addr_q  <= {req_addr_i[ADDR_W-1:2], 2'b00};
              bus_we_q    <= req_we_i;
              bus_be_q    <= be8_d[3:0];
              bus_wdata_q <= wd64_d[31:0];
            end
          end
        end
        REQ0: begin
          if (bus_gnt_i) begin
            bus_req_q <= 1'b0;
            state_q   <= RSP0;
          end
        end
        RSP0: begin
          if (bus_rvalid_i) begin
            lo_q <= bus_rdata_i;
            if (bus_err_i || !split_q) begin
              state_q      <= IDLE;
              ready_q      <= 1'b1;
              resp_valid_q <= 1'b1;
              resp_err_q   <= bus_err_i;
              resp_mis_q   <= mis_q;
              resp_rdata_q <= (bus_err_i || we_q) ? 32'b0
                            : load_align({32'b0, bus_rdata_i}, addr_q[1:0], size_q, signed_q);
            end else begin
              state_q     <= REQ1;
              bus_req_q   <= 1'b1;
              bus_addr_q  <= {addr_q[ADDR_W-1:2] + WORD_INC, 2'b00};
              bus_be_q    <= be8_q[7:4];
              bus_wdata_q <= wd64_q[63:32];
            end
          end
        end
        REQ1: begin
          if (bus_gnt_i) begin
            bus_req_q <= 1'b0;
            state_q   <= RSP1;
          end
        end
        RSP1: begin
          if (bus_rvalid_i) begin
            state_q      <= IDLE;
            ready_q      <= 1'b1;
            resp_valid_q <= 1'b1;
            resp_err_q   <= bus_err_i;
            resp_mis_q   <= mis_q;
            resp_rdata_q <= (bus_err_i || we_q) ? 32'b0
                          : load_align({bus_rdata_i, lo_q}, addr_q[1:0], size_q, signed_q);
          end
        end
        REJ: begin
          state_q      <= IDLE;
          ready_q      <= 1'b1;
          resp_valid_q <= 1'b1;
          resp_err_q   <= 1'b1;
          resp_mis_q   <= 1'b1;
          resp_rdata_q <= 32'b0;
        end
        default: begin
          state_q   <= IDLE;
          ready_q   <= 1'b1;
          bus_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready_o       = ready_q;
  assign resp_valid_o      = resp_valid_q;
  assign resp_rdata_o      = resp_rdata_q;
  assign resp_err_o        = resp_err_q;
  assign resp_misaligned_o = resp_mis_q;
  assign bus_req_o         = bus_req_q;
  assign bus_addr_o        = bus_addr_q;
  assign bus_we_o          = bus_we_q;
  assign bus_be_o          = bus_be_q;
  assign bus_wdata_o       = bus_wdata_q;

endmodule

// File: tb/tb_lsu_split_ctrl.sv
// tb/tb_lsu_split_ctrl.sv - directed bench for lsu_split_ctrl, split and reject variants
module tb_lsu_split_ctrl;
  import lsu_split_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  mem_size_e   req_size = MEM_WORD;
  logic        req_signed = 1'b0;
  logic        resp_valid, resp_err, resp_mis;
  logic [31:0] resp_rdata;
  logic        bus_req, bus_we;
  logic        bus_gnt = 1'b1;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_rvalid = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic        bus_err = 1'b0;

  logic        r_req_valid = 1'b0;
  logic        r_req_ready;
  logic        r_resp_valid, r_resp_err, r_resp_mis;
  logic [31:0] r_resp_rdata;
  logic        r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata;
  logic [3:0]  r_bus_be;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lsu_split_ctrl #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b1)) u_dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_signed_i(req_signed),
    .resp_valid_o(resp_valid), .resp_rdata_o(resp_rdata), .resp_err_o(resp_err),
    .resp_misaligned_o(resp_mis),
    .bus_req_o(bus_req), .bus_gnt_i(bus_gnt), .bus_addr_o(bus_addr), .bus_we_o(bus_we),
    .bus_be_o(bus_be), .bus_wdata_o(bus_wdata), .bus_rvalid_i(bus_rvalid),
    .bus_rdata_i(bus_rdata), .bus_err_i(bus_err)
  );

  lsu_split_ctrl #(.ADDR_W(32), .SPLIT_MISALIGNED(1'b0)) u_rej (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(r_req_valid), .req_ready_o(r_req_ready), .req_addr_i(req_addr),
    .req_we_i(req_we), .req_wdata_i(req_wdata), .req_size_i(req_size),
    .req_signed_i(req_signed),
    .resp_valid_o(r_resp_valid), .resp_rdata_o(r_resp_rdata), .resp_err_o(r_resp_err),
    .resp_misaligned_o(r_resp_mis),
    .bus_req_o(r_bus_req), .bus_gnt_i(1'b1), .bus_addr_o(r_bus_addr), .bus_we_o(r_bus_we),
    .bus_be_o(r_bus_be), .bus_wdata_o(r_bus_wdata), .bus_rvalid_i(1'b0),
    .bus_rdata_i(32'h0), .bus_err_i(1'b0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic we, input logic [31:0] wd,
                       input mem_size_e sz, input logic sgn);
    req_addr = a; req_we = we; req_wdata = wd; req_size = sz; req_signed = sgn;
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  // Expects to be called in a REQ cycle with bus_gnt already high.
  task automatic beat(input string tag, input logic [31:0] ea, input logic [3:0] ebe,
                      input logic ewe, input logic [31:0] ewd, input logic [31:0] rd,
                      input logic er);
    chk({tag, ".req"}, 32'(bus_req), 32'd1);
    chk({tag, ".addr"}, bus_addr, ea);
    chk({tag, ".be"}, 32'(bus_be), 32'(ebe));
    chk({tag, ".we"}, 32'(bus_we), 32'(ewe));
    chk({tag, ".wdata"}, bus_wdata, ewd);
    chk({tag, ".ready"}, 32'(req_ready), 32'd0);
    chk({tag, ".no_resp"}, 32'(resp_valid), 32'd0);
    tick();
    chk({tag, ".req_drop"}, 32'(bus_req), 32'd0);
    bus_rvalid = 1'b1; bus_rdata = rd; bus_err = er;
    tick();
    bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
  endtask

  task automatic resp(input string tag, input logic [31:0] rd, input logic er, input logic mis);
    chk({tag, ".valid"}, 32'(resp_valid), 32'd1);
    chk({tag, ".rdata"}, resp_rdata, rd);
    chk({tag, ".err"}, 32'(resp_err), 32'(er));
    chk({tag, ".mis"}, 32'(resp_mis), 32'(mis));
    chk({tag, ".ready"}, 32'(req_ready), 32'd1);
    chk({tag, ".bus_idle"}, 32'(bus_req), 32'd0);
    tick();
    chk({tag, ".pulse"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst.ready", 32'(req_ready), 32'd1);
    chk("rst.resp_valid", 32'(resp_valid), 32'd0);
    chk("rst.rdata", resp_rdata, 32'd0);
    chk("rst.err_mis", {30'b0, resp_err, resp_mis}, 32'd0);
    chk("rst.bus_req", 32'(bus_req), 32'd0);
    chk("rst.bus_fields", {bus_addr | bus_wdata}, 32'd0);
    chk("rst.bus_be_we", {27'b0, bus_be, bus_we}, 32'd0);

    issue(32'h100, 1'b0, 32'h0, MEM_WORD, 1'b0);
    beat("lw", 32'h100, 4'b1111, 1'b0, 32'h0, 32'hDEADBEEF, 1'b0);
    resp("lw.resp", 32'hDEADBEEF, 1'b0, 1'b0);

    issue(32'h103, 1'b0, 32'h0, MEM_BYTE, 1'b1);
    beat("lb", 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFFFF, 1'b0);
    resp("lb.resp", 32'hFFFFFF80, 1'b0, 1'b0);

    issue(32'h103, 1'b0, 32'h0, MEM_BYTE, 1'b0);
    beat("lbu", 32'h100, 4'b1000, 1'b0, 32'h0, 32'h80FFFFFF, 1'b0);
    resp("lbu.resp", 32'h00000080, 1'b0, 1'b0);

    issue(32'h202, 1'b1, 32'h11223344, MEM_WORD, 1'b0);
    beat("sw.b0", 32'h200, 4'b1100, 1'b1, 32'h33440000, 32'h0, 1'b0);
    beat("sw.b1", 32'h204, 4'b0011, 1'b1, 32'h00001122, 32'h5A5A5A5A, 1'b0);
    resp("sw.resp", 32'h0, 1'b0, 1'b1);

    issue(32'hFFFFFFFF, 1'b0, 32'h0, MEM_HALF, 1'b1);
    beat("lh.b0", 32'hFFFFFFFC, 4'b1000, 1'b0, 32'h0, 32'hAB000000, 1'b0);
    beat("lh.b1", 32'h00000000, 4'b0001, 1'b0, 32'h0, 32'h000000FF, 1'b0);
    resp("lh.resp", 32'hFFFFFFAB, 1'b0, 1'b1);

    issue(32'h101, 1'b0, 32'h0, MEM_WORD, 1'b0);
    beat("err.b0", 32'h100, 4'b1110, 1'b0, 32'h0, 32'h12345678, 1'b1);
    resp("err.resp", 32'h0, 1'b1, 1'b1);
    chk("err.no_beat2", 32'(bus_req), 32'd0);

    req_addr = 32'h1; req_we = 1'b0; req_size = MEM_HALF; req_signed = 1'b0;
    r_req_valid = 1'b1;
    tick();
    r_req_valid = 1'b0;
    chk("rej.t1.valid", 32'(r_resp_valid), 32'd0);
    chk("rej.t1.bus_req", 32'(r_bus_req), 32'd0);
    tick();
    chk("rej.valid", 32'(r_resp_valid), 32'd1);
    chk("rej.err", 32'(r_resp_err), 32'd1);
    chk("rej.mis", 32'(r_resp_mis), 32'd1);
    chk("rej.rdata", r_resp_rdata, 32'd0);
    chk("rej.ready", 32'(r_req_ready), 32'd1);
    chk("rej.bus_req", 32'(r_bus_req), 32'd0);
    tick();
    chk("rej.pulse", 32'(r_resp_valid), 32'd0);

    bus_gnt = 1'b0;
    issue(32'h300, 1'b1, 32'hCAFEF00D, MEM_WORD, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("stall.req", 32'(bus_req), 32'd1);
      chk("stall.addr", bus_addr, 32'h300);
      chk("stall.be", 32'(bus_be), 32'hF);
      chk("stall.wdata", bus_wdata, 32'hCAFEF00D);
      chk("stall.we", 32'(bus_we), 32'd1);
      tick();
    end
    rst_n = 1'b0;
    #1;
    chk("arst.bus_req", 32'(bus_req), 32'd0);
    chk("arst.bus_addr", bus_addr, 32'd0);
    chk("arst.bus_wdata", bus_wdata, 32'd0);
    chk("arst.bus_be_we", {27'b0, bus_be, bus_we}, 32'd0);
    chk("arst.ready", 32'(req_ready), 32'd1);
    tick();
    rst_n = 1'b1;
    bus_gnt = 1'b1;
    tick();
    chk("arst.no_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("arst.no_resp2", 32'(resp_valid), 32'd0);

    issue(32'h100, 1'b0, 32'h0, MEM_WORD, 1'b1);
    beat("lw2", 32'h100, 4'b1111, 1'b0, 32'h0, 32'h0BADF00D, 1'b0);
    resp("lw2.resp", 32'h0BADF00D, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
